// File: rtl/frac_divider.sv
// Unsigned fixed-point divider: Quotient = Dividend / Divisor with FRAC_W fraction bits,
// restoring shift-subtract one bit per cycle plus a guard bit for optional half-LSB rounding.
module frac_divider #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8,
    parameter int QUOT_W     = 24
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Round_en,
    input  logic [DIVIDEND_W-1:0] Dividend,
    input  logic [DIVISOR_W-1:0]  Divisor,
    output logic [QUOT_W-1:0]     Quotient,
    output logic                  Ack,
    output logic                  Busy,
    output logic                  DivZero
);
    localparam int FRAC_W = QUOT_W - DIVIDEND_W;
    localparam int CNT_W  = $clog2(QUOT_W + 1);

    typedef struct packed {
        logic [DIVIDEND_W-1:0] dividend;
        logic [DIVISOR_W-1:0]  divisor;
        logic                  round_en;
    } req_t;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state_q, state_d;
    req_t                  req_q;
    logic                  pend_q;
    logic                  armed_q;
    logic [DIVISOR_W:0]    rem_q;
    logic [DIVIDEND_W-1:0] dvd_sr_q;
    logic [QUOT_W-1:0]     q_sr_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  accept;
    logic                  div_zero;
    logic                  last_iter;
    logic [DIVISOR_W+1:0]  trial;
    logic                  ge;
    logic [DIVISOR_W:0]    diff;
    logic [QUOT_W:0]       rounded;
    logic [QUOT_W-1:0]     final_q;

    // Start is captured with the operands on one edge and acted on at the next;
    // armed_q blocks capture on the first edge after reset release.
    assign accept    = armed_q && !pend_q && (state_q != CALC) && Start;
    assign div_zero  = (req_q.divisor == '0);
    assign last_iter = (cnt_q == CNT_W'(QUOT_W));
    assign Busy      = (state_q == CALC);

    // Extended dividend is {Dividend, FRAC_W+1 zeros}; zeros shift in from the bottom.
    assign trial = {rem_q, dvd_sr_q[DIVIDEND_W-1]};
    assign ge    = (trial >= {2'b00, req_q.divisor});
    assign diff  = trial[DIVISOR_W:0] - {1'b0, req_q.divisor};

    // On the last iteration q_sr_q holds T and ge is the guard bit G.
    assign rounded = {1'b0, q_sr_q} + {{QUOT_W{1'b0}}, req_q.round_en & ge};
    assign final_q = rounded[QUOT_W] ? '1 : rounded[QUOT_W-1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (pend_q) state_d = div_zero ? DONE : CALC;
            CALC:       if (last_iter) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            armed_q  <= 1'b0;
            pend_q   <= 1'b0;
            req_q    <= '0;
            rem_q    <= '0;
            dvd_sr_q <= '0;
            q_sr_q   <= '0;
            cnt_q    <= '0;
            Quotient <= '0;
            Ack      <= 1'b0;
            DivZero  <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            pend_q  <= accept;
            if (accept) begin
                req_q <= '{dividend: Dividend, divisor: Divisor, round_en: Round_en};
            end
            if (pend_q) begin
                Ack      <= div_zero;
                DivZero  <= div_zero;
                rem_q    <= '0;
                dvd_sr_q <= req_q.dividend;
                q_sr_q   <= '0;
                cnt_q    <= '0;
                if (div_zero) Quotient <= '1;
            end else if (state_q == CALC) begin
                rem_q    <= ge ? diff : trial[DIVISOR_W:0];
                dvd_sr_q <= dvd_sr_q << 1;
                q_sr_q   <= {q_sr_q[QUOT_W-2:0], ge};
                cnt_q    <= cnt_q + CNT_W'(1);
                if (last_iter) begin
                    Quotient <= final_q;
                    Ack      <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_frac_divider.sv
// Self-checking bench for frac_divider: directed corner cases plus random operands
// against an arithmetic reference model.
module tb_frac_divider;
    localparam int DW = 16;
    localparam int SW = 8;
    localparam int QW = 24;
    localparam int FW = QW - DW;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Start;
    logic          Round_en;
    logic [DW-1:0] Dividend;
    logic [SW-1:0] Divisor;
    logic [QW-1:0] Quotient;
    logic          Ack;
    logic          Busy;
    logic          DivZero;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [QW-1:0] last_q;

    always #5 Clk = ~Clk;

    frac_divider #(.DIVIDEND_W(DW), .DIVISOR_W(SW), .QUOT_W(QW)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Round_en(Round_en),
        .Dividend(Dividend), .Divisor(Divisor),
        .Quotient(Quotient), .Ack(Ack), .Busy(Busy), .DivZero(DivZero)
    );

    function automatic logic [QW-1:0] ref_quot(input logic [DW-1:0] d, input logic [SW-1:0] s,
                                               input logic r);
        longint unsigned wide, t, g, sum, maxv;
        logic [63:0] sum_v;
        if (s == 0) return '1;
        wide  = 64'(d);
        wide  = (wide << (FW + 1)) / 64'(s);
        t     = wide >> 1;
        g     = wide & 64'd1;
        sum   = r ? t + g : t;
        maxv  = (64'd1 << QW) - 64'd1;
        sum_v = sum;
        return (sum > maxv) ? '1 : sum_v[QW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Returns at the negedge following the edge that samples Start.
    task automatic launch(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic r,
                          input bit hold);
        @(negedge Clk);
        Dividend = d;
        Divisor  = s;
        Round_en = r;
        Start    = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        if (!hold) Start = 1'b0;
    endtask

    task automatic wait_check(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic r,
                              input string tag);
        logic [QW-1:0] exp_q;
        int exp_lat, lat, busy_err, q_err;
        exp_q    = ref_quot(d, s, r);
        exp_lat  = (s == 0) ? 1 : QW + 2;
        lat      = 0;
        busy_err = 0;
        q_err    = 0;
        if (s == 0) chk({tag, "_busy_launch"}, 32'(Busy), 32'd0);
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (Ack) lat = n;
            else begin
                if (Busy !== (s != 0)) busy_err++;
                if (Quotient !== last_q) q_err++;
            end
        end
        chk({tag, "_ack_edge"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_quot"}, 32'(Quotient), 32'(exp_q));
        chk({tag, "_divzero"}, 32'(DivZero), 32'(s == 0));
        chk({tag, "_busy_calc"}, 32'(busy_err), 32'd0);
        chk({tag, "_quot_hold"}, 32'(q_err), 32'd0);
        chk({tag, "_busy_done"}, 32'(Busy), 32'd0);
        last_q = exp_q;
    endtask

    initial begin
        logic [DW-1:0] d2;
        logic [SW-1:0] s2;
        logic          r2;
        int            stray_ack;

        Reset    = 1'b0;
        Start    = 1'b0;
        Round_en = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        last_q   = '0;
        #12;
        chk("rst_quot", 32'(Quotient), 32'd0);
        chk("rst_ack", 32'(Ack), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_divzero", 32'(DivZero), 32'd0);
        @(negedge Clk);
        Reset = 1'b1;

        launch(16'h0003, 8'hFF, 1'b0, 1'b0);  wait_check(16'h0003, 8'hFF, 1'b0, "d3_ff");
        chk("d3_ff_val", 32'(Quotient), 32'h000003);
        launch(16'h0002, 8'h03, 1'b0, 1'b0);  wait_check(16'h0002, 8'h03, 1'b0, "d2_3_trunc");
        chk("d2_3_trunc_val", 32'(Quotient), 32'h0000AA);
        launch(16'h0002, 8'h03, 1'b1, 1'b0);  wait_check(16'h0002, 8'h03, 1'b1, "d2_3_round");
        chk("d2_3_round_val", 32'(Quotient), 32'h0000AB);
        launch(16'hFFFF, 8'h01, 1'b1, 1'b0);  wait_check(16'hFFFF, 8'h01, 1'b1, "ffff_1");
        chk("ffff_1_val", 32'(Quotient), 32'hFFFF00);
        launch(16'h1234, 8'h00, 1'b0, 1'b0);  wait_check(16'h1234, 8'h00, 1'b0, "divzero");
        chk("divzero_val", 32'(Quotient), 32'hFFFFFF);
        launch(16'hFFFF, 8'hFF, 1'b1, 1'b0);  wait_check(16'hFFFF, 8'hFF, 1'b1, "max_max");

        // Start held high, operands changed mid-run, then relaunch from DONE.
        launch(16'h0ABC, 8'h07, 1'b1, 1'b1);
        d2 = 16'h4321; s2 = 8'h05; r2 = 1'b0;
        Dividend = d2; Divisor = s2; Round_en = r2;
        wait_check(16'h0ABC, 8'h07, 1'b1, "hold");
        @(posedge Clk);
        @(negedge Clk);
        chk("relaunch_ack_pending", 32'(Ack), 32'd1);
        Start = 1'b0;
        wait_check(d2, s2, r2, "relaunch");

        // Reset in the middle of a calculation.
        launch(16'h1234, 8'h56, 1'b0, 1'b0);
        repeat (9) @(posedge Clk);
        #1 Reset = 1'b0;
        #1;
        chk("abort_quot", 32'(Quotient), 32'd0);
        chk("abort_ack", 32'(Ack), 32'd0);
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_divzero", 32'(DivZero), 32'd0);
        last_q = '0;
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        chk("release_busy", 32'(Busy), 32'd0);
        Start = 1'b0;
        stray_ack = 0;
        repeat (30) begin
            @(negedge Clk);
            if (Ack) stray_ack++;
        end
        chk("abort_no_ack", 32'(stray_ack), 32'd0);
        chk("abort_quot_idle", 32'(Quotient), 32'd0);
        launch(16'h0001, 8'h03, 1'b0, 1'b0);  wait_check(16'h0001, 8'h03, 1'b0, "post_rst");
        chk("post_rst_val", 32'(Quotient), 32'h000055);

        for (int i = 0; i < 40; i++) begin
            d2 = DW'($urandom);
            s2 = ($urandom_range(0, 4) == 0) ? '0 : SW'($urandom);
            r2 = 1'($urandom);
            if (i % 10 == 3) d2 = '1;
            if (i % 10 == 7 && s2 != 0) s2 = 8'h01;
            launch(d2, s2, r2, 1'b0);
            wait_check(d2, s2, r2, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/frac_divider.md
FRAC_DIVIDER -- requirements
Module: frac_divider

Interface
REQ-001 SHALL have parameter DIVIDEND_W, default 16, dividend width in bits.
REQ-002 SHALL have parameter DIVISOR_W, default 8, divisor width in bits.
REQ-003 SHALL have parameter QUOT_W, default 24, quotient width; FRAC_W = QUOT_W - DIVIDEND_W fraction bits, QUOT_W > DIVIDEND_W required.
REQ-004 SHALL have port Clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port Start  input  1  launch request, sampled on rising Clk.
REQ-007 SHALL have port Round_en  input  1  mode: 1 = half-LSB upward rounding, 0 = truncate.
REQ-008 SHALL have port Dividend  input  DIVIDEND_W  unsigned dividend.
REQ-009 SHALL have port Divisor  input  DIVISOR_W  unsigned divisor.
REQ-010 SHALL have port Quotient  output  QUOT_W  registered result.
REQ-011 SHALL have port Ack  output  1  result valid / run complete.
REQ-012 SHALL have port Busy  output  1  division in progress.
REQ-013 SHALL have port DivZero  output  1  last operation had zero divisor.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE.
REQ-015 SHALL, in IDLE or DONE with Start=1 at an edge, latch Dividend, Divisor, Round_en, clear Ack and DivZero, and enter CALC (nonzero divisor) or DONE (zero divisor).
REQ-016 SHALL ignore Start, Dividend, Divisor, Round_en changes while in CALC.
REQ-017 SHALL compute by restoring shift-subtract, one quotient bit per cycle, MSB first, CALC lasting exactly QUOT_W+1 cycles (QUOT_W bits plus one guard bit).
REQ-018 SHALL define T = floor(Dividend * 2^FRAC_W / Divisor) and G = guard bit = bit 0 of floor(Dividend * 2^(FRAC_W+1) / Divisor).
REQ-019 SHALL produce Quotient = T when Round_en latched 0, T + G when latched 1.
REQ-020 SHALL saturate Quotient to all-ones if T + G exceeds QUOT_W bits.
REQ-021 SHALL, on zero divisor, set Quotient = all-ones, DivZero = 1, Ack = 1 one edge after Start sampled.
REQ-022 SHALL, for nonzero divisor, with Start sampled at edge 0, raise Ack and update Quotient at edge QUOT_W+2 (26 at defaults).
REQ-023 SHALL hold Busy = 1 exactly while in CALC.
REQ-024 SHALL hold Ack = 1 and Quotient stable in DONE until Start restarts; Start=1 in DONE drops Ack next edge.
REQ-025 SHALL keep Quotient at its previous value during CALC (no partial results visible).
REQ-026 SHALL size internal remainder at DIVISOR_W+1 bits so no intermediate overflow occurs for any operands.

Reset
REQ-027 SHALL, on Reset low, asynchronously force IDLE, Quotient = 0, Ack = 0, Busy = 0, DivZero = 0, iteration counter = 0.
REQ-028 SHALL abort any CALC in progress on Reset and produce no Ack for the aborted operation.
REQ-029 SHALL not leave IDLE on the edge where Reset deasserts, even if Start = 1; Start sampled from the following edge.

Verification
REQ-030 SHALL verify Dividend=0x0003, Divisor=0xFF, Round_en=0 -> Quotient=0x000003, Ack at edge 26, DivZero=0.
REQ-031 SHALL verify Dividend=0x0002, Divisor=0x03: Round_en=0 -> 0x0000AA; Round_en=1 -> 0x0000AB.
REQ-032 SHALL verify Dividend=0xFFFF, Divisor=0x01, Round_en=1 -> Quotient=0xFFFF00, no saturation.
REQ-033 SHALL verify Dividend=0x1234, Divisor=0x00 -> Quotient=0xFFFFFF, DivZero=1, Ack at edge 1, Busy never high.
REQ-034 SHALL verify Reset low at CALC cycle 10, then released -> all outputs 0, IDLE, no Ack; subsequent 0x0001/0x03 run gives 0x000055.
REQ-035 SHALL verify Start held high through a run with inputs changed mid-CALC -> result uses launch-time operands; Start still high in DONE relaunches and drops Ack next edge.
